// File: rtl/clock_divider_multi.sv
// Multi-channel programmable divider: per-channel divided clock and period-start tick,
// with shadowed divisors applied at the period boundary. Define CLKDIV_SYNC_EN to add sync_req.
module clock_divider_multi #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int CH_W        = 1,
  parameter int DIV_DEFAULT = 3908
) (
  input  logic              inclk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [WIDTH-1:0]  div_data,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_req,
`endif
  output logic              div_err,
  output logic [NUM_CH-1:0] div_busy,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_MIN  = WIDTH'(2);
  localparam logic [31:0]      NUM_CH_U = 32'(NUM_CH);

  logic [WIDTH-1:0]  cnt_q [NUM_CH];
  logic [WIDTH-1:0]  cnt_d [NUM_CH];
  logic [WIDTH-1:0]  div_act_q [NUM_CH];
  logic [WIDTH-1:0]  div_act_d [NUM_CH];
  logic [WIDTH-1:0]  div_shadow_q [NUM_CH];
  logic [WIDTH-1:0]  div_shadow_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] outclk_q, outclk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              div_err_q, div_err_d;
  logic              wr_ok;
  logic              sync_all;

`ifdef CLKDIV_SYNC_EN
  assign sync_all = sync_req;
`else
  assign sync_all = 1'b0;
`endif

  assign wr_ok = div_wr && (div_data >= DIV_MIN) && (32'(div_ch) < NUM_CH_U);

  always_comb begin
    div_err_d = div_wr && !wr_ok;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]        = cnt_q[i];
      div_act_d[i]    = div_act_q[i];
      div_shadow_d[i] = div_shadow_q[i];
      pend_d[i]       = pend_q[i];
      if (!en[i]) begin
        // Parked one short of the new divisor so the first enabled edge wraps.
        if (pend_q[i]) div_act_d[i] = div_shadow_q[i];
        pend_d[i] = 1'b0;
        cnt_d[i]  = div_act_d[i] - ONE;
      end else if (sync_all || (cnt_q[i] == div_act_q[i] - ONE)) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_act_d[i] = div_shadow_q[i];
          pend_d[i]    = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
      // A write landing on a wrap is staged after the old shadow was consumed.
      if (wr_ok && (div_ch == CH_W'(i))) begin
        div_shadow_d[i] = div_data;
        pend_d[i]       = 1'b1;
      end
      outclk_d[i] = en[i] && (cnt_d[i] < (div_act_d[i] >> 1));
      tick_d[i]   = en[i] && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= DIV_RST - ONE;
        div_act_q[i]    <= DIV_RST;
        div_shadow_q[i] <= DIV_RST;
      end
      pend_q    <= '0;
      outclk_q  <= '0;
      tick_q    <= '0;
      div_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]        <= cnt_d[i];
        div_act_q[i]    <= div_act_d[i];
        div_shadow_q[i] <= div_shadow_d[i];
      end
      pend_q    <= pend_d;
      outclk_q  <= outclk_d;
      tick_q    <= tick_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_err  = div_err_q;
  assign div_busy = pend_q;
  assign outclk   = outclk_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (NUM_CH=2, CH_W=2, DIV_DEFAULT=3908).
module tb_clock_divider_multi;
  logic        inclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = 2'b00;
  logic        div_wr = 1'b0;
  logic [1:0]  div_ch = 2'b00;
  logic [31:0] div_data = 32'd0;
`ifdef CLKDIV_SYNC_EN
  logic        sync_req = 1'b0;
`endif
  logic        div_err;
  logic [1:0]  div_busy, outclk, tick;

  int n_vec = 0;
  int n_err = 0;

  always #5 inclk = ~inclk;

  clock_divider_multi #(
    .NUM_CH(2), .WIDTH(32), .CH_W(2), .DIV_DEFAULT(3908)
  ) dut (
    .inclk(inclk), .rst_n(rst_n), .en(en), .div_wr(div_wr), .div_ch(div_ch),
    .div_data(div_data),
`ifdef CLKDIV_SYNC_EN
    .sync_req(sync_req),
`endif
    .div_err(div_err), .div_busy(div_busy), .outclk(outclk), .tick(tick)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge inclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 2'b00; div_wr = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic write_div(input logic [1:0] ch, input logic [31:0] d);
    div_wr = 1'b1; div_ch = ch; div_data = d;
    step(1);
    div_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 2'b11; div_wr = 1'b0;
    step(2);
    n_vec++; if ({outclk, tick} !== 4'b0000) begin n_err++; $display("FAIL reset_out got=%b want=0000", {outclk, tick}); end
    n_vec++; if ({div_busy, div_err} !== 3'b000) begin n_err++; $display("FAIL reset_status got=%b want=000", {div_busy, div_err}); end
    rst_n = 1'b1; en = 2'b00;
  endtask

  task automatic test_default_period();
    int hi, tk, ch1;
    logic at1953, at1954;
    do_reset();
    en = 2'b01;
    step(1);
    n_vec++; if ({outclk, tick} !== 4'b0101) begin n_err++; $display("FAIL first_tick got=%b want=0101", {outclk, tick}); end
    hi = int'(outclk[0]); tk = 0; ch1 = 0; at1953 = 1'b0; at1954 = 1'b1;
    for (int c = 1; c < 3908; c++) begin
      step(1);
      hi += int'(outclk[0]);
      tk += int'(tick[0]);
      ch1 += int'(outclk[1] | tick[1]);
      if (c == 1953) at1953 = outclk[0];
      if (c == 1954) at1954 = outclk[0];
    end
    n_vec++; if (hi !== 1954) begin n_err++; $display("FAIL default_high_cycles got=%0d want=1954", hi); end
    n_vec++; if (tk !== 0) begin n_err++; $display("FAIL default_mid_ticks got=%0d want=0", tk); end
    n_vec++; if ({at1953, at1954} !== 2'b10) begin n_err++; $display("FAIL default_fall_edge got=%b want=10", {at1953, at1954}); end
    n_vec++; if (ch1 !== 0) begin n_err++; $display("FAIL ch1_idle got=%0d want=0", ch1); end
    step(1);
    n_vec++; if ({outclk[0], tick[0]} !== 2'b11) begin n_err++; $display("FAIL default_second_tick got=%b want=11", {outclk[0], tick[0]}); end
  endtask

  task automatic test_write_midperiod();
    logic [9:0] ob, tb;
    do_reset();
    en = 2'b11;
    step(1);
    n_vec++; if (tick !== 2'b11) begin n_err++; $display("FAIL wr_start_tick got=%b want=11", tick); end
    step(10);
    write_div(2'd1, 32'd5);
    n_vec++; if ({div_busy, div_err} !== 3'b100) begin n_err++; $display("FAIL wr_busy_set got=%b want=100", {div_busy, div_err}); end
    step(3896);
    n_vec++; if ({div_busy[1], outclk[1], tick[1]} !== 3'b100) begin n_err++; $display("FAIL wr_before_wrap got=%b want=100", {div_busy[1], outclk[1], tick[1]}); end
    step(1);
    n_vec++; if (div_busy[1] !== 1'b0) begin n_err++; $display("FAIL wr_busy_clear got=%b want=0", div_busy[1]); end
    ob = '0; tb = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      ob[k] = outclk[1];
      tb[k] = tick[1];
    end
    n_vec++; if (ob !== 10'b0001100011) begin n_err++; $display("FAIL div5_outclk got=%b want=0001100011", ob); end
    n_vec++; if (tb !== 10'b0000100001) begin n_err++; $display("FAIL div5_tick got=%b want=0000100001", tb); end
  endtask

  task automatic test_reject_and_min();
    logic [3:0] ob, tb;
    do_reset();
    write_div(2'd0, 32'd1);
    n_vec++; if ({div_err, div_busy} !== 3'b100) begin n_err++; $display("FAIL err_small got=%b want=100", {div_err, div_busy}); end
    step(1);
    n_vec++; if (div_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_width got=%b want=0", div_err); end
    write_div(2'd3, 32'd7);
    n_vec++; if ({div_err, div_busy} !== 3'b100) begin n_err++; $display("FAIL err_bad_ch got=%b want=100", {div_err, div_busy}); end
    step(1);
    n_vec++; if (div_err !== 1'b0) begin n_err++; $display("FAIL err_pulse_width2 got=%b want=0", div_err); end
    write_div(2'd1, 32'd2);
    n_vec++; if ({div_err, div_busy} !== 3'b010) begin n_err++; $display("FAIL min_accept got=%b want=010", {div_err, div_busy}); end
    step(1);
    n_vec++; if (div_busy !== 2'b00) begin n_err++; $display("FAIL min_applied_idle got=%b want=00", div_busy); end
    en = 2'b11;
    ob = '0; tb = '0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      ob[k] = outclk[1];
      tb[k] = tick[1];
    end
    n_vec++; if ({ob, tb} !== 8'b0101_0101) begin n_err++; $display("FAIL div2_pattern got=%b want=01010101", {ob, tb}); end
    step(1950);
    n_vec++; if (outclk[0] !== 1'b1) begin n_err++; $display("FAIL ch0_unchanged_hi got=%b want=1", outclk[0]); end
    step(1);
    n_vec++; if (outclk[0] !== 1'b0) begin n_err++; $display("FAIL ch0_unchanged_lo got=%b want=0", outclk[0]); end
    step(1954);
    n_vec++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL ch0_unchanged_tick got=%b want=1", tick[0]); end
  endtask

  task automatic test_write_on_wrap();
    logic [9:0] ob, tb, bb;
    do_reset();
    en = 2'b01;
    step(1);
    write_div(2'd0, 32'd6);
    n_vec++; if (div_busy[0] !== 1'b1) begin n_err++; $display("FAIL wrap_pend_set got=%b want=1", div_busy[0]); end
    step(3906);
    write_div(2'd0, 32'd4);
    ob = '0; tb = '0; bb = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step(1);
      ob[k] = outclk[0];
      tb[k] = tick[0];
      bb[k] = div_busy[0];
    end
    n_vec++; if (ob !== 10'b0011000111) begin n_err++; $display("FAIL wrap_wr_outclk got=%b want=0011000111", ob); end
    n_vec++; if (tb !== 10'b0001000001) begin n_err++; $display("FAIL wrap_wr_tick got=%b want=0001000001", tb); end
    n_vec++; if (bb !== 10'b0000111111) begin n_err++; $display("FAIL wrap_wr_busy got=%b want=0000111111", bb); end
  endtask

  task automatic test_reset_midperiod();
    do_reset();
    en = 2'b01;
    step(1);
    write_div(2'd0, 32'd9);
    step(99);
    n_vec++; if ({outclk[0], div_busy[0]} !== 2'b11) begin n_err++; $display("FAIL pre_reset got=%b want=11", {outclk[0], div_busy[0]}); end
    rst_n = 1'b0;
    step(1);
    n_vec++; if ({outclk, tick, div_busy} !== 6'b000000) begin n_err++; $display("FAIL midreset_out got=%b want=000000", {outclk, tick, div_busy}); end
    rst_n = 1'b1;
    step(1);
    n_vec++; if ({outclk[0], tick[0]} !== 2'b11) begin n_err++; $display("FAIL restart_tick got=%b want=11", {outclk[0], tick[0]}); end
    step(1953);
    n_vec++; if (outclk[0] !== 1'b1) begin n_err++; $display("FAIL restart_hi got=%b want=1", outclk[0]); end
    step(1);
    n_vec++; if (outclk[0] !== 1'b0) begin n_err++; $display("FAIL restart_lo got=%b want=0", outclk[0]); end
    step(1954);
    n_vec++; if (tick[0] !== 1'b1) begin n_err++; $display("FAIL restart_period got=%b want=1", tick[0]); end
  endtask

  task automatic test_sync();
    logic [1:0] exp0, exp7, exp10;
    do_reset();
    write_div(2'd0, 32'd7);
    write_div(2'd1, 32'd10);
    step(1);
    en = 2'b01;
    step(4);
    en = 2'b11;
    step(3);
`ifdef CLKDIV_SYNC_EN
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    exp0 = 2'b11; exp7 = 2'b01; exp10 = 2'b10;
`else
    step(1);
    exp0 = 2'b01; exp7 = 2'b11; exp10 = 2'b00;
`endif
    n_vec++; if (tick !== exp0) begin n_err++; $display("FAIL sync_s0 got=%b want=%b", tick, exp0); end
    step(7);
    n_vec++; if (tick !== exp7) begin n_err++; $display("FAIL sync_s7 got=%b want=%b", tick, exp7); end
    step(3);
    n_vec++; if (tick !== exp10) begin n_err++; $display("FAIL sync_s10 got=%b want=%b", tick, exp10); end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_write_midperiod();
    test_reject_and_min();
    test_write_on_wrap();
    test_reset_midperiod();
    test_sync();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
